muldiv_controller: RTL and testbench
====================================

Name: muldiv_controller

Overview:
- Sequences a shared iterative multiply/divide datapath and the architectural HI/LO registers on behalf of the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops carrying post-forwarding operands from the execute stage.
- Runs multi-cycle ops one bit per cycle.
- Raises a stall to hazard control whenever the execute-stage instruction needs the unit, or needs HI/LO, while an op is in flight.

Parameters:
- WIDTH, 32, operand width; also the iteration count for MUL/DIV.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- start_e_i  input  1  execute-stage instruction is a mul/div/mthi/mtlo op.
- op_e_i  input  3  op code: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; all others are no-op.
- src_a_e_i  input  WIDTH  rs operand after forwarding; dividend/multiplicand; MTHI/MTLO data.
- src_b_e_i  input  WIDTH  rt operand after forwarding; divisor/multiplier.
- flush_e_i  input  1  execute instruction is squashed; suppresses acceptance this cycle.
- read_hi_lo_e_i  input  1  execute instruction is MFHI/MFLO.
- busy_o  output  1  op in flight.
- stall_o  output  1  stall request to hazard unit.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.
- div_by_zero_o  output  1  one-cycle pulse on DIV/DIVU with src_b == 0.

Behaviour:
- Reset (rst_i low, any time, including mid-op):
  - State goes to IDLE; counter, HI, LO and working registers clear to 0.
  - busy_o, stall_o and div_by_zero_o go to 0.
- Accept condition: state IDLE & start_e_i & !flush_e_i & valid op. Ops presented while busy are never accepted; the stall holds them in E until the unit is IDLE.
- FSM states:
  - IDLE: on accepted MTHI/MTLO, write src_a into HI/LO at that edge and stay IDLE (0-cycle busy). On accepted MUL*/DIV* with nonzero divisor, latch operand magnitudes (signed ops) or raw values (unsigned ops) plus result-sign flags, load counter = WIDTH, go to ITER.
  - ITER: one shift-add (MUL) or restoring subtract-shift (DIV) step per cycle; counter decrements; at counter == 1, go to FIX.
  - FIX: apply sign correction, write HI/LO at this edge, return to IDLE.
- Sign rules:
  - Product is negated when operand signs differ (signed MULT only).
  - Signed quotient is negative when signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 yields LO = 0x80000000, HI = 0.
- Divide by zero:
  - Accepted DIV/DIVU with src_b == 0 goes IDLE -> FIX directly.
  - At FIX: LO = all ones, HI = src_a.
  - div_by_zero_o is high during the FIX cycle.
- Latency: accept at edge t → busy_o high for WIDTH+1 cycles (WIDTH ITER + 1 FIX). HI/LO are valid the cycle busy_o falls. Divide-by-zero: busy for 1 cycle.
- busy_o = (state != IDLE), registered.
- stall_o is combinational: busy_o & ((start_e_i & !flush_e_i) | read_hi_lo_e_i).
- MFHI/MFLO in E on the cycle after FIX sees the new HI/LO with no stall.
- flush_e_i does not abort an in-flight op: an op that has left E is committed and completes.
- Simultaneous start_e_i and flush_e_i in IDLE: nothing is accepted and HI/LO are unchanged.

Optional Feature:
- MULDIV_EARLY_OUT_EN
- Defined: during ITER on MULT/MULTU, when the remaining multiplier shift register is zero, jump to FIX on the next edge and shift the partial product by the remaining count. Busy time becomes (index of highest set multiplier bit + 1) + 1 FIX cycle; a zero multiplier gives 1 ITER + FIX. DIV timing is unchanged.
- Undefined: every multiply takes exactly WIDTH ITER cycles.

Test Plan:
- Reset mid-DIV (rst_i low during ITER count 10) → busy_o = 0, HI = LO = 0 immediately; next MTLO 0x5 → LO = 0x5 in 1 cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 9 / 0 → 1 busy cycle, div_by_zero_o pulse, LO = 0xFFFFFFFF, HI = 9.
- MFHI presented 2 cycles after DIVU accept → stall_o high until busy_o falls; MFHI then returns the quotient-correct HI.
- Back-to-back MULT while busy → stall_o = 1, second op accepted the cycle busy_o falls.
- MULT with flush_e_i = 1 → not accepted, busy_o stays 0.
- With MULDIV_EARLY_OUT_EN: MULTU 3 × 5 → busy_o high 4 cycles (3 ITER + FIX), LO = 15. Without the macro → 33 cycles, same result.

Source files
------------

// File: rtl/muldiv_controller.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the remaining multiplier bits are zero.
module muldiv_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_e_i,
    input  logic [2:0]       op_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic             flush_e_i,
    input  logic             read_hi_lo_e_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;   // product high half / partial remainder
    logic [WIDTH-1:0] mreg;  // product low half + multiplier / dividend -> quotient
    logic [WIDTH-1:0] dreg;  // multiplicand / divisor
    logic [CW-1:0]    cnt;
    logic             is_div, neg_q, neg_r, dbz;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] mplr;  // multiplier bits not yet consumed
`endif

    logic             valid_op, accept, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b, op_a, op_b;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] mul_next, prod_fix;

    always_comb begin
        valid_op  = (op_e_i >= OP_MULT) && (op_e_i <= OP_MTLO);
        accept    = (state == IDLE) && start_e_i && !flush_e_i && valid_op;
        is_signed = (op_e_i == OP_MULT) || (op_e_i == OP_DIV);
        a_neg     = src_a_e_i[WIDTH-1];
        b_neg     = src_b_e_i[WIDTH-1];
        abs_a     = a_neg ? -src_a_e_i : src_a_e_i;
        abs_b     = b_neg ? -src_b_e_i : src_b_e_i;
        op_a      = is_signed ? abs_a : src_a_e_i;
        op_b      = is_signed ? abs_b : src_b_e_i;
        mul_sum   = {1'b0, acc} + (mreg[0] ? {1'b0, dreg} : '0);
        mul_next  = {mul_sum, mreg[WIDTH-1:1]};
        div_sh    = {acc, mreg[WIDTH-1]};
        div_diff  = {1'b0, div_sh} - {2'b0, dreg};
        div_ok    = !div_diff[WIDTH+1];
        prod_fix  = neg_q ? -{acc, mreg} : {acc, mreg};
        stall_o   = busy_o && ((start_e_i && !flush_e_i) || read_hi_lo_e_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            acc           <= '0;
            mreg          <= '0;
            dreg          <= '0;
            cnt           <= '0;
            is_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dbz           <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            busy_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mplr          <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    case (op_e_i)
                        OP_MTHI: hi_o <= src_a_e_i;
                        OP_MTLO: lo_o <= src_a_e_i;
                        OP_MULT, OP_MULTU: begin
                            acc    <= '0;
                            dreg   <= op_a;
                            mreg   <= op_b;
`ifdef MULDIV_EARLY_OUT_EN
                            mplr   <= op_b;
`endif
                            neg_q  <= is_signed && (a_neg ^ b_neg);
                            neg_r  <= 1'b0;
                            is_div <= 1'b0;
                            dbz    <= 1'b0;
                            cnt    <= CW'(WIDTH);
                            busy_o <= 1'b1;
                            state  <= ITER;
                        end
                        default: begin
                            is_div <= 1'b1;
                            busy_o <= 1'b1;
                            if (src_b_e_i == '0) begin
                                // HI receives the raw dividend
                                acc           <= src_a_e_i;
                                dbz           <= 1'b1;
                                div_by_zero_o <= 1'b1;
                                state         <= FIX;
                            end else begin
                                acc   <= '0;
                                mreg  <= op_a;
                                dreg  <= op_b;
                                neg_q <= is_signed && (a_neg ^ b_neg);
                                neg_r <= is_signed && a_neg;
                                dbz   <= 1'b0;
                                cnt   <= CW'(WIDTH);
                                state <= ITER;
                            end
                        end
                    endcase
                end
                ITER: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIX;
                    if (is_div) begin
                        acc  <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        mreg <= {mreg[WIDTH-2:0], div_ok};
                    end else begin
`ifdef MULDIV_EARLY_OUT_EN
                        mplr <= mplr >> 1;
                        if (mplr[WIDTH-1:1] == '0) begin
                            // remaining steps would only shift; do them all at once
                            {acc, mreg} <= mul_next >> (cnt - CW'(1));
                            state       <= FIX;
                        end else begin
                            {acc, mreg} <= mul_next;
                        end
`else
                        {acc, mreg} <= mul_next;
`endif
                    end
                end
                FIX: begin
                    if (dbz) begin
                        lo_o <= '1;
                        hi_o <= acc;
                    end else if (is_div) begin
                        lo_o <= neg_q ? -mreg : mreg;
                        hi_o <= neg_r ? -acc : acc;
                    end else begin
                        {hi_o, lo_o} <= prod_fix;
                    end
                    dbz           <= 1'b0;
                    div_by_zero_o <= 1'b0;
                    busy_o        <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: vector table, corner sequences, random vs model.
module tb_muldiv_controller;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i, start_e_i, flush_e_i, read_hi_lo_e_i;
    logic [2:0]   op_e_i;
    logic [W-1:0] src_a_e_i, src_b_e_i;
    logic         busy_o, stall_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    muldiv_controller #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_e_i(start_e_i), .op_e_i(op_e_i),
        .src_a_e_i(src_a_e_i), .src_b_e_i(src_b_e_i), .flush_e_i(flush_e_i),
        .read_hi_lo_e_i(read_hi_lo_e_i), .busy_o(busy_o), .stall_o(stall_o),
        .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    int n_tests = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_cyc(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int msb;
        if (op == 3'd3 || op == 3'd4) return (b == 0) ? 1 : W + 1;
        if (op != 3'd1 && op != 3'd2) return 0;
`ifdef MULDIV_EARLY_OUT_EN
        m = (op == 3'd1 && b[31]) ? -b : b;
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return msb + 2;
`else
        m = b;
        msb = 0;
        return W + 1 + msb - int'(m == m ? 0 : 0);
`endif
    endfunction

    // Architectural reference: updates m_hi/m_lo from plain arithmetic
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0] up;
        int qa, qb;
        case (op)
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); {m_hi, m_lo} = sp; end
            3'd2: begin up = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = up; end
            3'd3: begin
                qa = a; qb = b;
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin m_lo = a; m_hi = 0; end
                else begin m_lo = qa / qb; m_hi = qa % qb; end
            end
            3'd4: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit dbz_seen);
        @(negedge clk_i);
        start_e_i = 1'b1; op_e_i = op; src_a_e_i = a; src_b_e_i = b;
        @(posedge clk_i); #1;
        start_e_i = 1'b0;
        cyc = 0; dbz_seen = 1'b0;
        while (busy_o && cyc < 100) begin
            dbz_seen |= div_by_zero_o;
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        int cyc;
        bit dbz;
        ref_op(op, a, b);
        run_op(op, a, b, cyc, dbz);
        chk({name, "_hi"}, hi_o, m_hi);
        chk({name, "_lo"}, lo_o, m_lo);
        chk({name, "_busy_cycles"}, cyc, exp_cyc(op, b));
        chk({name, "_dbz"}, dbz, (op == 3'd3 || op == 3'd4) && b == 0);
    endtask

    vec_t tbl[12];

    initial begin
        int cyc, guard, bad;
        bit dbz;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001};
        tbl[1]  = '{3'd1, 32'hffff_fffd, 32'd5,         32'hffff_ffff, 32'hffff_fff1};
        tbl[2]  = '{3'd3, 32'hffff_fff9, 32'd2,         32'hffff_ffff, 32'hffff_fffd};
        tbl[3]  = '{3'd3, 32'h8000_0000, 32'hffff_ffff, 32'h0,         32'h8000_0000};
        tbl[4]  = '{3'd4, 32'd9,         32'd0,         32'd9,         32'hffff_ffff};
        tbl[5]  = '{3'd2, 32'd3,         32'd5,         32'h0,         32'd15};
        tbl[6]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[7]  = '{3'd5, 32'hcafe_f00d, 32'd0,         32'hcafe_f00d, 32'd14};
        tbl[8]  = '{3'd6, 32'h1234_5678, 32'd0,         32'hcafe_f00d, 32'h1234_5678};
        tbl[9]  = '{3'd3, 32'd7,         32'hffff_fffe, 32'd1,         32'hffff_fffd};
        tbl[10] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        tbl[11] = '{3'd3, 32'hffff_fff9, 32'd0,         32'hffff_fff9, 32'hffff_ffff};

        rst_i = 1'b0; start_e_i = 1'b0; flush_e_i = 1'b0; read_hi_lo_e_i = 1'b0;
        op_e_i = '0; src_a_e_i = '0; src_b_e_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_stall", stall_o, 0);
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_dbz", div_by_zero_o, 0);
        @(negedge clk_i) rst_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc, dbz);
            chk($sformatf("vec%0d_hi", i), hi_o, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), lo_o, tbl[i].lo);
            chk($sformatf("vec%0d_cycles", i), cyc, exp_cyc(tbl[i].op, tbl[i].b));
            chk($sformatf("vec%0d_dbz", i), dbz, (tbl[i].op == 3'd3 || tbl[i].op == 3'd4) && tbl[i].b == 0);
        end
        m_hi = tbl[11].hi; m_lo = tbl[11].lo;

        // MFHI waits behind an in-flight DIVU
        @(negedge clk_i);
        start_e_i = 1'b1; op_e_i = 3'd4; src_a_e_i = 32'd100; src_b_e_i = 32'd7;
        @(posedge clk_i); #1;
        start_e_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("busy_no_request_no_stall", stall_o, 0);
        read_hi_lo_e_i = 1'b1;
        #1;
        guard = 0; bad = 0;
        while (busy_o && guard < 100) begin
            if (!stall_o) bad++;
            @(posedge clk_i); #1;
            guard++;
        end
        chk("mfhi_stall_while_busy", bad, 0);
        chk("mfhi_wait_bound", busy_o, 0);
        chk("mfhi_no_stall_after", stall_o, 0);
        chk("mfhi_hi", hi_o, 32'd2);
        read_hi_lo_e_i = 1'b0;

        // second MULT held in E until the unit is idle
        @(negedge clk_i);
        start_e_i = 1'b1; op_e_i = 3'd1; src_a_e_i = 32'hffff_fffd; src_b_e_i = 32'd5;
        @(posedge clk_i); #1;
        op_e_i = 3'd2; src_a_e_i = 32'd6; src_b_e_i = 32'd7;
        #1;
        guard = 0; bad = 0;
        while (busy_o && guard < 100) begin
            if (!stall_o) bad++;
            @(posedge clk_i); #1;
            guard++;
        end
        chk("b2b_stall_while_busy", bad, 0);
        chk("b2b_first_cycles", guard, exp_cyc(3'd1, 32'd5));
        chk("b2b_gap_no_stall", stall_o, 0);
        chk("b2b_first_hi", hi_o, 32'hffff_ffff);
        chk("b2b_first_lo", lo_o, 32'hffff_fff1);
        @(posedge clk_i); #1;
        start_e_i = 1'b0;
        chk("b2b_second_accepted", busy_o, 1);
        cyc = 0;
        while (busy_o && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("b2b_second_cycles", cyc, exp_cyc(3'd2, 32'd7));
        chk("b2b_second_hi", hi_o, 0);
        chk("b2b_second_lo", lo_o, 32'd42);
        m_hi = 0; m_lo = 32'd42;

        // flushed op is dropped
        @(negedge clk_i);
        start_e_i = 1'b1; flush_e_i = 1'b1; op_e_i = 3'd1; src_a_e_i = 32'd3; src_b_e_i = 32'd3;
        @(posedge clk_i); #1;
        chk("flush_not_busy", busy_o, 0);
        start_e_i = 1'b0; flush_e_i = 1'b0;
        @(posedge clk_i); #1;
        chk("flush_still_idle", busy_o, 0);
        chk("flush_hi_kept", hi_o, 0);
        chk("flush_lo_kept", lo_o, 32'd42);

        // asynchronous reset in the middle of a divide
        check_op("mthi_pre_reset", 3'd5, 32'h0000_0abc, 32'd0);
        @(negedge clk_i);
        start_e_i = 1'b1; op_e_i = 3'd3; src_a_e_i = 32'd1000; src_b_e_i = 32'd3;
        @(posedge clk_i); #1;
        start_e_i = 1'b0;
        repeat (22) @(posedge clk_i);
        #1;
        chk("pre_reset_busy", busy_o, 1);
        rst_i = 1'b0;
        #1;
        chk("midreset_busy", busy_o, 0);
        chk("midreset_hi", hi_o, 0);
        chk("midreset_lo", lo_o, 0);
        chk("midreset_stall", stall_o, 0);
        @(negedge clk_i) rst_i = 1'b1;
        m_hi = 0; m_lo = 0;
        check_op("mtlo_after_reset", 3'd6, 32'd5, 32'd0);

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(1, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 0;
                1: begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
                2: rb = rb >> $urandom_range(0, 31);
                3: ra = -($urandom_range(0, 100));
                default: ;
            endcase
            check_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
